// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the two-client cache-line memory arbiter:
//   FSM state encoding, requester identifiers, default widths and the
//   round-robin grant helper.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int LINE_W_DEF = 128;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } arb_state_t;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  // Choose the winner among the pending requesters. On a tie the requester
  // that did not win last time gets the grant, so neither side can starve.
  function automatic logic pick_owner(input logic ic_pending,
                                      input logic dc_pending,
                                      input logic last_owner);
    logic win;
    if (ic_pending && dc_pending) begin
      win = ~last_owner;
    end else if (dc_pending) begin
      win = OWNER_DC;
    end else begin
      win = OWNER_IC;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates line-fill requests from an icache and fill/eviction requests
//   from a dcache onto a single main-memory port. One transaction is in
//   flight at a time: IDLE picks a requester and latches its command,
//   MEM_WAIT holds the command on the memory port until mem_ready, RESP
//   pulses the owner's ack for one cycle.
//
// Ports
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   ic_req, ic_addr       : icache line-fill request / line address
//   ic_ack, ic_rdata      : icache completion pulse / fill data (held)
//   dc_req, dc_we,
//   dc_addr, dc_wdata     : dcache fill (we=0) or dirty eviction (we=1)
//   dc_ack, dc_rdata      : dcache completion pulse / fill data (held)
//   mem_req, mem_we,
//   mem_addr, mem_wdata   : main-memory command, held until mem_ready
//   mem_ready, mem_rdata  : memory completion pulse / read data
//   busy                  : a transaction is in progress (state != IDLE)
//   owner                 : current or most recent grant (0=icache, 1=dcache)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,

  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,

  output logic              busy,
  output logic              owner
);

  arb_state_t state;
  logic       grant;

  // The owner register doubles as the round-robin history: it keeps the
  // last grant after the transaction finishes and resets to the icache,
  // so the first tie after reset goes to the dcache.
  assign grant = pick_owner(ic_req, dc_req, owner);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      busy      <= 1'b0;
      owner     <= OWNER_IC;
    end else begin
      unique case (state)
        // IDLE: grant and latch the winning command
        ST_IDLE: begin
          ic_ack <= 1'b0;
          dc_ack <= 1'b0;
          if (ic_req || dc_req) begin
            owner   <= grant;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_MEM_WAIT;
            if (grant == OWNER_DC) begin
              mem_addr  <= dc_addr;
              mem_we    <= dc_we;
              mem_wdata <= dc_wdata;
            end else begin
              // The icache only ever reads.
              mem_addr  <= ic_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end

        // MEM_WAIT: command held on the memory port until mem_ready
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (owner == OWNER_DC) begin
              dc_ack <= 1'b1;
              // Evictions leave the previous fill data in place.
              if (!mem_we) begin
                dc_rdata <= mem_rdata;
              end
            end else begin
              ic_ack   <= 1'b1;
              ic_rdata <= mem_rdata;
            end
          end
        end

        // RESP: the ack raised on entry lasts exactly this one cycle
        ST_RESP: begin
          ic_ack <= 1'b0;
          dc_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          ic_ack  <= 1'b0;
          dc_ack  <= 1'b0;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;
  localparam int MEM_LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          ic_ack, dc_ack;
  logic [LW-1:0] ic_rdata, dc_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference memory and scoreboards ----------------
  typedef struct { logic own; logic [LW-1:0] rdata; } sb_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [LW-1:0] wdata; } mc_t;

  sb_t           sb_q[$];
  mc_t           mc_q[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] mdl_mem [logic [AW-1:0]];
  logic [LW-1:0] exp_ic_last, exp_dc_last;

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a, a + 32'd7, a ^ 32'hFFFF_0000};
  endfunction

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic push_ic(input logic [AW-1:0] a);
    exp_ic_last = ref_rd(a);
    sb_q.push_back('{1'b0, exp_ic_last});
    mc_q.push_back('{a, 1'b0, '0});
  endtask

  task automatic push_dc(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    if (we) ref_mem[a] = wd;
    else    exp_dc_last = ref_rd(a);
    sb_q.push_back('{1'b1, exp_dc_last});
    mc_q.push_back('{a, we, wd});
  endtask

  // ---------------- mem_model: fixed-latency memory ----------------
  int  ready_fires = 0;
  initial begin : mem_model
    bit            pend;
    int            cnt;
    mc_t           cap, exp_mc;
    pend      = 0;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (pend) begin
        cnt++;
        if (mem_req) begin
          chk("mem_addr_hold", LW'(mem_addr), LW'(cap.addr));
          chk("mem_we_hold", LW'(mem_we), LW'(cap.we));
          if (cap.we) chk("mem_wdata_hold", mem_wdata, cap.wdata);
        end
        if (cnt == MEM_LAT) begin
          pend = 0;
          ready_fires++;
          mem_ready = 1'b1;
          if (cap.we) mdl_mem[cap.addr] = cap.wdata;
          else mem_rdata = mdl_mem.exists(cap.addr) ? mdl_mem[cap.addr] : dflt(cap.addr);
        end
      end else if (mem_req) begin
        pend = 1;
        cnt  = 0;
        cap  = '{mem_addr, mem_we, mem_wdata};
        chk("mem_cmd_expected", LW'(mc_q.size() != 0), LW'(1));
        if (mc_q.size() != 0) begin
          exp_mc = mc_q.pop_front();
          chk("mem_addr", LW'(mem_addr), LW'(exp_mc.addr));
          chk("mem_we", LW'(mem_we), LW'(exp_mc.we));
          if (exp_mc.we) chk("mem_wdata", mem_wdata, exp_mc.wdata);
        end
      end
    end
  end

  // ---------------- ack monitor ----------------
  int ic_ack_cnt = 0;
  int dc_ack_cnt = 0;
  always @(negedge clk) begin
    sb_t e;
    if (ic_ack || dc_ack) begin
      if (ic_ack) ic_ack_cnt++;
      if (dc_ack) dc_ack_cnt++;
      chk("ack_onehot", LW'(ic_ack & dc_ack), LW'(0));
      chk("ack_in_resp", LW'(busy), LW'(1));
      chk("sb_nonempty", LW'(sb_q.size() != 0), LW'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ack_side", LW'(dc_ack), LW'(e.own));
        chk("owner", LW'(owner), LW'(e.own));
        chk("rdata", dc_ack ? dc_rdata : ic_rdata, e.rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    exp_ic_last = '0;
    exp_dc_last = '0;
  endtask

  task automatic do_txn(input logic dc, input logic we, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd, input logic perturb);
    logic got;
    if (dc) push_dc(we, a, wd);
    else    push_ic(a);
    @(negedge clk);
    if (dc) begin
      dc_we = we; dc_addr = a; dc_wdata = wd; dc_req = 1'b1;
    end else begin
      ic_addr = a; ic_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (perturb && i == 2) begin
        dc_addr = ~a; dc_wdata = ~wd; dc_we = ~we; ic_addr = ~a;
      end
      if (dc ? dc_ack : ic_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", LW'(got), LW'(1));
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int  k, gap, n_ack, base_ic, base_dc, base_rdy;
    bit  got, stray;
    logic [LW-1:0] a5;

    reset = 1'b1;
    ic_req = 0; dc_req = 0; dc_we = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    exp_ic_last = '0; exp_dc_last = '0;
    a5 = {16{8'hA5}};
    ref_mem[32'h100] = a5;
    mdl_mem[32'h100] = a5;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", LW'(mem_req), LW'(0));
    chk("rst_mem_we", LW'(mem_we), LW'(0));
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_owner", LW'(owner), LW'(0));
    chk("rst_acks", LW'({ic_ack, dc_ack}), LW'(0));
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    chk("rst_mem_addr", LW'(mem_addr), LW'(0));
    chk("rst_mem_wdata", mem_wdata, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // icache fill with latency measurement
    push_ic(32'h100);
    ic_addr = 32'h100;
    ic_req  = 1'b1;
    @(posedge clk); #1;
    chk("lat_mem_req", LW'(mem_req), LW'(1));
    chk("lat_busy", LW'(busy), LW'(1));
    chk("lat_owner", LW'(owner), LW'(0));
    k = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      k++;
      if (ic_ack) begin got = 1; break; end
    end
    chk("lat_ack_seen", LW'(got), LW'(1));
    chk("lat_cycles", LW'(k), LW'(MEM_LAT + 1));
    chk("lat_dc_ack", LW'(dc_ack), LW'(0));
    @(negedge clk);
    ic_req = 1'b0;
    repeat (2) @(negedge clk);

    // dcache eviction, inputs disturbed mid-transaction
    base_dc = dc_ack_cnt;
    do_txn(1'b1, 1'b1, 32'h200, LW'(32'h1234), 1'b1);
    chk("wr_ack_once", LW'(dc_ack_cnt - base_dc), LW'(1));
    chk("wr_dc_rdata", dc_rdata, '0);
    // read back the evicted line, then another icache fill
    do_txn(1'b1, 1'b0, 32'h200, '0, 1'b0);
    do_txn(1'b0, 1'b0, 32'h3C0, '0, 1'b1);
    chk("ic_rdata_hold", ic_rdata, exp_ic_last);

    // simultaneous requests from reset: dcache first, one idle cycle between
    apply_reset(2);
    @(negedge clk);
    push_dc(1'b0, 32'h300, '0);
    push_ic(32'h140);
    dc_addr = 32'h300; dc_we = 1'b0; ic_addr = 32'h140;
    dc_req = 1'b1; ic_req = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dc_ack) begin got = 1; break; end
    end
    chk("tie_dc_first", LW'(got), LW'(1));
    dc_req = 1'b0;
    gap = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (ic_ack) begin got = 1; break; end
    end
    chk("tie_ic_second", LW'(got), LW'(1));
    chk("tie_gap", LW'(gap), LW'(MEM_LAT + 3));
    ic_req = 1'b0;
    repeat (2) @(negedge clk);

    // both held for four transactions: D,I,D,I
    push_dc(1'b0, 32'h400, '0);
    push_ic(32'h180);
    push_dc(1'b0, 32'h400, '0);
    push_ic(32'h180);
    dc_addr = 32'h400; dc_we = 1'b0; ic_addr = 32'h180;
    dc_req = 1'b1; ic_req = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ic_ack || dc_ack) n_ack++;
      if (n_ack == 4) break;
    end
    chk("rr_four_acks", LW'(n_ack), LW'(4));
    dc_req = 1'b0; ic_req = 1'b0;
    repeat (3) @(negedge clk);

    // reset three cycles into MEM_WAIT discards the transaction
    mc_q.push_back('{32'h500, 1'b0, '0});
    dc_addr = 32'h500; dc_we = 1'b0; dc_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin got = 1; break; end
    end
    chk("abort_mem_req_seen", LW'(got), LW'(1));
    repeat (3) @(negedge clk);
    base_ic = ic_ack_cnt; base_dc = dc_ack_cnt; base_rdy = ready_fires;
    dc_req = 1'b0;
    reset  = 1'b1;
    #1;
    chk("abort_mem_req", LW'(mem_req), LW'(0));
    chk("abort_busy", LW'(busy), LW'(0));
    chk("abort_owner", LW'(owner), LW'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_ic_last = '0; exp_dc_last = '0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || ic_ack || dc_ack || mem_req) stray = 1;
    end
    chk("abort_quiet", LW'(stray), LW'(0));
    chk("abort_no_ack", LW'((ic_ack_cnt - base_ic) + (dc_ack_cnt - base_dc)), LW'(0));
    chk("abort_late_ready", LW'(ready_fires - base_rdy), LW'(1));
    chk("abort_dc_rdata", dc_rdata, '0);

    // requester reissues after the abort
    do_txn(1'b0, 1'b0, 32'h100, '0, 1'b0);
    chk("reissue_ic_rdata", ic_rdata, a5);

    chk("sb_drained", LW'(sb_q.size()), LW'(0));
    chk("mc_drained", LW'(mc_q.size()), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, meaning cache-line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ic_req in 1, ic_addr in ADDR_W: icache line-fill request and line address.
REQ-006 SHALL have ports ic_ack out 1, ic_rdata out LINE_W: icache completion pulse and fill data.
REQ-007 SHALL have ports dc_req in 1, dc_we in 1, dc_addr in ADDR_W, dc_wdata in LINE_W: dcache fill (we=0) or dirty-line eviction (we=1).
REQ-008 SHALL have ports dc_ack out 1, dc_rdata out LINE_W: dcache completion pulse and fill data.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out LINE_W: main-memory command.
REQ-010 SHALL have ports mem_ready in 1, mem_rdata in LINE_W: memory completion pulse and read data.
REQ-011 SHALL have ports busy out 1 (state != IDLE) and owner out 1 (0=icache, 1=dcache, current/last grant).

Function
REQ-012 SHALL implement FSM states IDLE, MEM_WAIT, RESP.
REQ-013 IDLE: if any req high, SHALL grant one requester, latch its addr/we/wdata and owner, go to MEM_WAIT; else stay.
REQ-014 Arbitration: one requester high -> grant it; both high -> grant the one not granted last (round-robin via last_owner); after reset, last_owner = icache, so first tie goes to dcache.
REQ-015 icache grants SHALL always force mem_we = 0.
REQ-016 MEM_WAIT: mem_req SHALL be 1 with latched mem_addr/mem_we/mem_wdata held constant until mem_ready.
REQ-017 On mem_ready in MEM_WAIT: if read, SHALL register mem_rdata into owner's rdata; go to RESP; mem_req drops next cycle.
REQ-018 RESP: SHALL assert owner's ack for exactly one cycle, then return to IDLE.
REQ-019 Writes SHALL still pulse dc_ack; dc_rdata unchanged on writes.
REQ-020 ic_rdata/dc_rdata SHALL hold last fill value until next fill for same requester.
REQ-021 Requester SHALL drop req on the edge sampling its ack; arbiter reevaluates in IDLE next cycle (one idle cycle between transactions minimum).
REQ-022 Latency: req sampled at edge T -> mem_req high T+1 -> mem_ready at T+1+N -> ack high T+2+N.
REQ-023 mem_ready in IDLE or RESP SHALL be ignored.
REQ-024 req changes during MEM_WAIT/RESP SHALL not alter the latched transaction.
REQ-025 Never more than one ack high in any cycle; ack never high outside RESP.

Reset
REQ-026 reset SHALL immediately force state IDLE, mem_req/mem_we/ic_ack/dc_ack/busy = 0, owner = 0, last_owner = icache, rdata/mem_addr/mem_wdata = 0.
REQ-027 Reset mid-transaction SHALL discard it with no ack; requester must reissue.

Structure
REQ-028 Shared defs file SHALL hold state encoding, OWNER_IC/OWNER_DC constants, LINE_W default.
REQ-029 Single module, no sub-module; bench SHALL supply a fixed-latency memory model mem_model (N=5).

Verification
REQ-030 ic_req, ic_addr=0x100, mem holds 0xA5..A5: mem_req at T+1, ic_ack at T+7, ic_rdata=0xA5..A5, dc_ack=0.
REQ-031 dc_req we=1 addr=0x200 wdata=0x1234: mem_we=1, mem_wdata=0x1234 while mem_req; dc_ack once; dc_rdata unchanged.
REQ-032 ic_req and dc_req together from reset: dcache served first, icache next after one IDLE cycle; owner 1 then 0.
REQ-033 Both held continuously for 4 transactions: grants alternate D,I,D,I; no starvation.
REQ-034 reset pulsed 3 cycles into MEM_WAIT: mem_req=0, busy=0 immediately, no ack; later mem_ready ignored.
